// File: rtl/mem_txn_arbiter.sv
// Round-robin arbiter that shares one memory port between the icache and the dcache.
// A granted request is locked until memory completes it or the watchdog aborts it.
module mem_txn_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int BLK_SIZE = 128,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ic_req_valid_i,
  input  logic [ADDR_W-1:0]     ic_req_addr_i,
  output logic                  ic_res_valid_o,
  output logic                  ic_res_err_o,
  output logic [BLK_SIZE-1:0]   ic_res_blk_o,
  input  logic                  dc_req_valid_i,
  input  logic [ADDR_W-1:0]     dc_req_addr_i,
  input  logic                  dc_req_rw_i,
  input  logic [1:0]            dc_req_rw_type_i,
  input  logic [BLK_SIZE-1:0]   dc_req_wdata_i,
  output logic                  dc_res_valid_o,
  output logic                  dc_res_err_o,
  output logic [BLK_SIZE-1:0]   dc_res_data_o,
  output logic                  mem_req_valid_o,
  output logic [ADDR_W-1:0]     mem_req_addr_o,
  output logic [BLK_SIZE/8-1:0] mem_req_rw_o,
  output logic [BLK_SIZE-1:0]   mem_req_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [BLK_SIZE-1:0]   mem_rdata_i,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam int STRB_W  = BLK_SIZE / 8;
  localparam int BOFFSET = $clog2(STRB_W);
  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic WD_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t              state_r;
  logic                last_d_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                mem_valid_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [STRB_W-1:0]   strb_r;
  logic [BLK_SIZE-1:0] wdata_r;
  logic                busy_r;
  logic                timeout_r;
  logic                to_hit_s;
  logic                done_s;

  // Shifted lanes that fall off the top of the block are silently dropped.
  function automatic logic [STRB_W-1:0] calc_strb(input logic rw, input logic [1:0] rw_type,
                                                  input logic [BOFFSET-1:0] off);
    logic [STRB_W-1:0] s;
    s = '0;
    if (!rw) begin
      s = '0;
    end else begin
      case (rw_type)
        2'd1:    s = {{(STRB_W-1){1'b0}}, 1'b1} << off;
        2'd2:    s = {{(STRB_W-2){1'b0}}, 2'b11} << off;
        2'd3:    s = '1;
        default: s = '0;
      endcase
    end
    return s;
  endfunction

  // Completion detection; a same-cycle mem_ready_i takes priority over the watchdog.
  always_comb begin
    to_hit_s = 1'b0;
    done_s   = 1'b0;
    if (state_r != IDLE) begin
      to_hit_s = WD_EN && (cnt_r == TO_VAL) && !mem_ready_i;
      done_s   = mem_ready_i || to_hit_s;
    end else begin
      to_hit_s = 1'b0;
      done_s   = 1'b0;
    end
  end

  // Responses are steered only to the owner of the current grant.
  always_comb begin
    ic_res_valid_o = 1'b0;
    ic_res_err_o   = 1'b0;
    ic_res_blk_o   = '0;
    dc_res_valid_o = 1'b0;
    dc_res_err_o   = 1'b0;
    dc_res_data_o  = '0;
    if (state_r == GNT_I) begin
      ic_res_valid_o = done_s;
      ic_res_err_o   = to_hit_s;
      ic_res_blk_o   = mem_ready_i ? mem_rdata_i : '0;
    end else if (state_r == GNT_D) begin
      dc_res_valid_o = done_s;
      dc_res_err_o   = to_hit_s;
      dc_res_data_o  = mem_ready_i ? mem_rdata_i : '0;
    end else begin
      ic_res_valid_o = 1'b0;
      dc_res_valid_o = 1'b0;
    end
  end

  // Arbitration FSM with transaction capture and watchdog counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      last_d_r    <= 1'b1;
      cnt_r       <= '0;
      mem_valid_r <= 1'b0;
      addr_r      <= '0;
      strb_r      <= '0;
      wdata_r     <= '0;
      busy_r      <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (ic_req_valid_i && (!dc_req_valid_i || last_d_r)) begin
            state_r     <= GNT_I;
            last_d_r    <= 1'b0;
            addr_r      <= ic_req_addr_i;
            strb_r      <= '0;
            wdata_r     <= '0;
            mem_valid_r <= 1'b1;
            busy_r      <= 1'b1;
          end else if (dc_req_valid_i) begin
            state_r     <= GNT_D;
            last_d_r    <= 1'b1;
            addr_r      <= dc_req_addr_i;
            strb_r      <= calc_strb(dc_req_rw_i, dc_req_rw_type_i,
                                     dc_req_addr_i[BOFFSET-1:0]);
            wdata_r     <= dc_req_wdata_i;
            mem_valid_r <= 1'b1;
            busy_r      <= 1'b1;
          end
        end
        GNT_I, GNT_D: begin
          if (done_s) begin
            state_r     <= IDLE;
            mem_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            if (to_hit_s) begin
              timeout_r <= 1'b1;
            end
          end else if (WD_EN && (cnt_r != TO_VAL)) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r     <= IDLE;
          mem_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_valid_o = mem_valid_r;
  assign mem_req_addr_o  = addr_r;
  assign mem_req_rw_o    = strb_r;
  assign mem_req_wdata_o = wdata_r;
  assign busy_o          = busy_r;
  assign timeout_o       = timeout_r;

endmodule
